// File: rtl/el2_exu_mul_arb.sv
// Shares one multiplier between a priority pipeline port and a valid/ready port with a starvation guard.
// Issue is combinational and the result returns one cycle later; port 1 results wait in a one-entry buffer under backpressure.
typedef struct packed {
   logic valid;
   logic rs1_sign;
   logic rs2_sign;
   logic low;
} el2_mul_pkt_t;

module el2_exu_mul_arb #(
   parameter int STARVE_MAX = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  el2_mul_pkt_t p0_mul_p,
   input  logic [31:0]  p0_rs1,
   input  logic [31:0]  p0_rs2,
   output logic         p0_stall,
   output logic         p0_rsp_valid,
   output logic [31:0]  p0_rsp_data,
   input  el2_mul_pkt_t p1_mul_p,
   input  logic [31:0]  p1_rs1,
   input  logic [31:0]  p1_rs2,
   output logic         p1_ready,
   output logic         p1_rsp_valid,
   input  logic         p1_rsp_ready,
   output logic [31:0]  p1_rsp_data,
   output el2_mul_pkt_t mul_p,
   output logic [31:0]  mul_rs1,
   output logic [31:0]  mul_rs2,
   input  logic [31:0]  mul_result_x
);

   localparam int CW = $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

   logic          x0_vld_q, x0_vld_d;
   logic          x1_vld_q, x1_vld_d;
   logic          buf_vld_q, buf_vld_d;
   logic [31:0]   buf_dat_q, buf_dat_d;
   logic [CW-1:0] starve_q, starve_d;

   logic p1_ok, force1, grant0, grant1;

   // Port 1 may only issue when its previous result is guaranteed a place to land.
   always_comb begin
      p1_ok  = ~buf_vld_q & ~(x1_vld_q & ~p1_rsp_ready);
      force1 = (starve_q == STARVE_LIM) & p1_mul_p.valid & p1_ok;
      grant0 = p0_mul_p.valid & ~force1;
      grant1 = p1_mul_p.valid & p1_ok & (~p0_mul_p.valid | force1);
   end

   assign p0_stall = p0_mul_p.valid & force1;
   assign p1_ready = grant1;

   always_comb begin
      mul_p       = grant1 ? p1_mul_p : p0_mul_p;
      mul_p.valid = grant0 | grant1;
      mul_rs1     = grant1 ? p1_rs1 : p0_rs1;
      mul_rs2     = grant1 ? p1_rs2 : p0_rs2;
   end

   always_comb begin
      x0_vld_d  = grant0;
      x1_vld_d  = grant1;
      buf_vld_d = buf_vld_q;
      buf_dat_d = buf_dat_q;
      if (x1_vld_q & ~p1_rsp_ready & ~buf_vld_q) begin
         buf_vld_d = 1'b1;
         buf_dat_d = mul_result_x;
      end else if (buf_vld_q & p1_rsp_ready) begin
         buf_vld_d = 1'b0;
      end

      // force1 blocks grant0 at the limit, so the counter saturates at STARVE_MAX.
      starve_d = starve_q;
      if (grant1 | ~p1_mul_p.valid)
         starve_d = '0;
      else if (p1_mul_p.valid & p1_ok & grant0)
         starve_d = starve_q + CW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x0_vld_q  <= 1'b0;
         x1_vld_q  <= 1'b0;
         buf_vld_q <= 1'b0;
         buf_dat_q <= '0;
         starve_q  <= '0;
      end else begin
         x0_vld_q  <= x0_vld_d;
         x1_vld_q  <= x1_vld_d;
         buf_vld_q <= buf_vld_d;
         buf_dat_q <= buf_dat_d;
         starve_q  <= starve_d;
      end
   end

   assign p0_rsp_valid = x0_vld_q;
   assign p0_rsp_data  = mul_result_x;
   assign p1_rsp_valid = buf_vld_q | x1_vld_q;
   assign p1_rsp_data  = buf_vld_q ? buf_dat_q : mul_result_x;

endmodule

// File: tb/tb_el2_exu_mul_arb.sv
// Randomised bench for el2_exu_mul_arb: a transaction-level model (pending-result slot, loss counter)
// predicts every output each cycle; directed cases pin the model with hand-computed values.
module tb_el2_exu_mul_arb;

   localparam int SMAX = 4;

   logic         clk, rst;
   el2_mul_pkt_t p0_mul_p, p1_mul_p, mul_p;
   logic [31:0]  p0_rs1, p0_rs2, p1_rs1, p1_rs2, mul_rs1, mul_rs2, mul_result_x;
   logic [31:0]  p0_rsp_data, p1_rsp_data;
   logic         p0_stall, p0_rsp_valid, p1_ready, p1_rsp_valid, p1_rsp_ready;

   el2_exu_mul_arb #(.STARVE_MAX(SMAX)) dut (
      .clk(clk), .rst(rst),
      .p0_mul_p(p0_mul_p), .p0_rs1(p0_rs1), .p0_rs2(p0_rs2),
      .p0_stall(p0_stall), .p0_rsp_valid(p0_rsp_valid), .p0_rsp_data(p0_rsp_data),
      .p1_mul_p(p1_mul_p), .p1_rs1(p1_rs1), .p1_rs2(p1_rs2),
      .p1_ready(p1_ready), .p1_rsp_valid(p1_rsp_valid), .p1_rsp_ready(p1_rsp_ready),
      .p1_rsp_data(p1_rsp_data),
      .mul_p(mul_p), .mul_rs1(mul_rs1), .mul_rs2(mul_rs2), .mul_result_x(mul_result_x)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // Transaction-level model state
   int          m_losses;          // consecutive eligible cycles port 1 lost to port 0
   logic        m_p0_v;
   logic [31:0] m_p0_d;
   logic        m_p1_v;            // a port 1 result is waiting for the consumer
   logic        m_p1_fresh;        // ...and it was issued in the previous cycle
   logic [31:0] m_p1_d;
   logic        m_win0, m_win1;
   logic [31:0] mres_next;

   // Samples of the last compared cycle, for directed literal checks
   logic        s_p0_stall, s_p1_ready, s_mul_vld, s_p0_rv, s_p1_rv;
   logic [31:0] s_p0_rd, s_p1_rd;

   function automatic logic [31:0] prod(el2_mul_pkt_t p, logic [31:0] a, logic [31:0] b);
      longint sa, sb;
      logic [63:0] r;
      sa = p.rs1_sign ? longint'($signed(a)) : longint'({32'b0, a});
      sb = p.rs2_sign ? longint'($signed(b)) : longint'({32'b0, b});
      r  = 64'(sa * sb);
      return p.low ? r[31:0] : r[63:32];
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock cycle: compare at negedge, advance model, return at posedge+1 with result driven.
   task automatic tick();
      logic ok, elig1, w0, w1;
      el2_mul_pkt_t sel;
      @(negedge clk);
      if (rst) begin
         m_losses = 0; m_p0_v = 0; m_p1_v = 0; m_p1_fresh = 0;
      end
      ok    = !m_p1_v || (m_p1_fresh && p1_rsp_ready);
      elig1 = p1_mul_p.valid && ok;
      w1    = elig1 && (!p0_mul_p.valid || m_losses == SMAX);
      w0    = p0_mul_p.valid && !(elig1 && m_losses == SMAX);
      m_win0 = w0; m_win1 = w1;

      chk("p0_stall", 32'(p0_stall), 32'(p0_mul_p.valid && !w0));
      chk("p1_ready", 32'(p1_ready), 32'(w1));
      chk("mul_vld", 32'(mul_p.valid), 32'(w0 || w1));
      if (w0 || w1) begin
         sel = w1 ? p1_mul_p : p0_mul_p;
         chk("mul_pkt", 32'({mul_p.rs1_sign, mul_p.rs2_sign, mul_p.low}),
             32'({sel.rs1_sign, sel.rs2_sign, sel.low}));
         chk("mul_rs1", mul_rs1, w1 ? p1_rs1 : p0_rs1);
         chk("mul_rs2", mul_rs2, w1 ? p1_rs2 : p0_rs2);
      end
      chk("p0_rsp_valid", 32'(p0_rsp_valid), 32'(m_p0_v));
      if (m_p0_v) chk("p0_rsp_data", p0_rsp_data, m_p0_d);
      chk("p1_rsp_valid", 32'(p1_rsp_valid), 32'(m_p1_v));
      if (m_p1_v) chk("p1_rsp_data", p1_rsp_data, m_p1_d);

      s_p0_stall = p0_stall; s_p1_ready = p1_ready; s_mul_vld = mul_p.valid;
      s_p0_rv = p0_rsp_valid; s_p0_rd = p0_rsp_data;
      s_p1_rv = p1_rsp_valid; s_p1_rd = p1_rsp_data;

      // The multiplier itself: consumes whatever the DUT actually issued.
      mres_next = mul_p.valid ? prod(mul_p, mul_rs1, mul_rs2) : $urandom;

      if (!rst) begin
         m_p0_v = w0;
         m_p0_d = prod(p0_mul_p, p0_rs1, p0_rs2);
         if (m_p1_v && p1_rsp_ready) m_p1_v = 0;
         else if (m_p1_v)            m_p1_fresh = 0;
         if (w1) begin
            m_p1_v = 1; m_p1_fresh = 1; m_p1_d = prod(p1_mul_p, p1_rs1, p1_rs2);
         end
         if (!p1_mul_p.valid || w1) m_losses = 0;
         else if (elig1 && w0)       m_losses++;
      end
      @(posedge clk);
      #1;
      mul_result_x = mres_next;
   endtask

   function automatic logic [31:0] rnd_op();
      case ($urandom_range(0, 5))
         0: return 32'hFFFF_FFFF;
         1: return 32'h8000_0000;
         2: return 32'h0;
         default: return $urandom;
      endcase
   endfunction

   task automatic contention(input string tag);
      p0_mul_p = '{1'b1, 1'b1, 1'b1, 1'b1}; p0_rs1 = 32'd3; p0_rs2 = 32'd5;
      p1_mul_p = '{1'b1, 1'b0, 1'b0, 1'b1}; p1_rs1 = 32'd7; p1_rs2 = 32'd11;
      p1_rsp_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         tick();
         chk({tag, "_stall"}, 32'(s_p0_stall), 32'(c == 4));
         chk({tag, "_p1rdy"}, 32'(s_p1_ready), 32'(c == 4));
      end
      p0_mul_p = '0; p1_mul_p = '0;
      tick();
   endtask

   initial begin
      m_losses = 0; m_p0_v = 0; m_p0_d = 0; m_p1_v = 0; m_p1_fresh = 0; m_p1_d = 0;
      m_win0 = 0; m_win1 = 0; mres_next = 0;
      rst = 1'b1; p0_mul_p = '0; p1_mul_p = '0;
      p0_rs1 = 0; p0_rs2 = 0; p1_rs1 = 0; p1_rs2 = 0; p1_rsp_ready = 1'b1; mul_result_x = 0;

      // Reset state
      tick();
      chk("rst_p0_rv", 32'(s_p0_rv), 32'd0);
      chk("rst_p1_rv", 32'(s_p1_rv), 32'd0);
      chk("rst_mul_vld", 32'(s_mul_vld), 32'd0);
      rst = 1'b0;
      tick();

      // Port 0 signed: -1 * 2
      p0_mul_p = '{1'b1, 1'b1, 1'b1, 1'b1}; p0_rs1 = 32'hFFFF_FFFF; p0_rs2 = 32'h2;
      tick();
      chk("p0_issue", 32'({s_mul_vld, s_p0_stall}), 32'b10);
      p0_mul_p.low = 1'b0;
      tick();
      chk("p0_low", s_p0_rd, 32'hFFFF_FFFE);
      chk("p0_low_v", 32'(s_p0_rv), 32'd1);
      p0_mul_p = '0;
      tick();
      chk("p0_high", s_p0_rd, 32'hFFFF_FFFF);

      // Port 1 unsigned high
      p1_mul_p = '{1'b1, 1'b0, 1'b0, 1'b0}; p1_rs1 = 32'hFFFF_FFFF; p1_rs2 = 32'hFFFF_FFFF;
      tick();
      chk("p1_uh_rdy", 32'(s_p1_ready), 32'd1);
      p1_mul_p = '0;
      tick();
      chk("p1_uh_v", 32'(s_p1_rv), 32'd1);
      chk("p1_uh_d", s_p1_rd, 32'hFFFF_FFFE);

      contention("cont");

      // Backpressure through the holding buffer
      p1_mul_p = '{1'b1, 1'b0, 1'b0, 1'b1}; p1_rs1 = 32'd7; p1_rs2 = 32'd6; p1_rsp_ready = 1'b0;
      tick();
      chk("bp_issue", 32'(s_p1_ready), 32'd1);
      p1_rs1 = 32'd1; p1_rs2 = 32'd1;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("bp_hold_d", s_p1_rd, 32'd42);
         chk("bp_hold_rdy", 32'(s_p1_ready), 32'd0);
      end
      p1_rsp_ready = 1'b1;
      tick();
      chk("bp_drain_d", s_p1_rd, 32'd42);
      chk("bp_drain_rdy", 32'(s_p1_ready), 32'd0);
      tick();
      chk("bp_next_rdy", 32'(s_p1_ready), 32'd1);
      p1_mul_p = '0;
      tick();
      chk("bp_next_d", s_p1_rd, 32'd1);

      // Back-to-back port 1
      for (int k = 0; k < 6; k++) begin
         if (k < 5) begin
            p1_mul_p = '{1'b1, 1'b0, 1'b0, 1'b1}; p1_rs1 = 32'(k + 2); p1_rs2 = 32'd3;
         end else p1_mul_p = '0;
         tick();
         if (k < 5) chk("b2b_rdy", 32'(s_p1_ready), 32'd1);
         if (k >= 1) chk("b2b_d", s_p1_rd, 32'((k + 1) * 3));
      end

      // Reset with buffer full and port 0 in flight
      p1_rsp_ready = 1'b0;
      p1_mul_p = '{1'b1, 1'b0, 1'b0, 1'b1}; p1_rs1 = 32'd9; p1_rs2 = 32'd9;
      tick();
      p1_mul_p = '0;
      tick();
      p0_mul_p = '{1'b1, 1'b0, 1'b0, 1'b1}; p0_rs1 = 32'd4; p0_rs2 = 32'd5;
      tick();
      chk("rb_buf_d", s_p1_rd, 32'd81);
      p0_mul_p = '0;
      chk("rb_pre_p0", 32'(p0_rsp_valid), 32'd1);
      chk("rb_pre_p1", 32'(p1_rsp_valid), 32'd1);
      rst = 1'b1;
      #1;
      chk("rb_now_p0", 32'(p0_rsp_valid), 32'd0);
      chk("rb_now_p1", 32'(p1_rsp_valid), 32'd0);
      tick();
      rst = 1'b0; p1_rsp_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("rb_quiet", 32'({s_p0_rv, s_p1_rv}), 32'd0);
      end
      contention("post_rst");

      // Randomised traffic
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 199) == 0);
         if (!p0_mul_p.valid || m_win0) begin
            p0_mul_p = '{($urandom_range(0, 9) < 6), 1'($urandom), 1'($urandom), 1'($urandom)};
            p0_rs1 = rnd_op(); p0_rs2 = rnd_op();
         end
         if (!p1_mul_p.valid || m_win1) begin
            p1_mul_p = '{($urandom_range(0, 9) < 6), 1'($urandom), 1'($urandom), 1'($urandom)};
            p1_rs1 = rnd_op(); p1_rs2 = rnd_op();
         end
         p1_rsp_ready = ($urandom_range(0, 3) != 0);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
